// File: rtl/emu_osc_pkg.sv
// Shared types and helpers for the emulated-time oscillator.
// Used by the timekeeper datapath and its config shadow.
package emu_osc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH
   } osc_state_t;

   function automatic logic [63:0] dt_max(input int unsigned w);
      if (w >= 64) return '1;
      return (64'd1 << w) - 64'd1;
   endfunction

   // A zero half-period would stall time, so it becomes one LSB.
   function automatic logic [63:0] clamp1(input logic [63:0] v);
      return (v == '0) ? 64'd1 : v;
   endfunction

endpackage

// File: rtl/emu_osc_timekeeper_if.sv
// Half-period configuration handshake between a host and the
// oscillator.
interface emu_osc_timekeeper_if #(
   parameter int DT_WIDTH = 27
);

   logic                cfg_valid;
   logic                cfg_ready;
   logic [DT_WIDTH-1:0] cfg_lo;
   logic [DT_WIDTH-1:0] cfg_hi;

   modport master (
      output cfg_valid,
      output cfg_lo,
      output cfg_hi,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_lo,
      input  cfg_hi,
      output cfg_ready
   );

endinterface

// File: rtl/emu_osc_cfg_shadow.sv
// One-deep shadow for new half-periods; held until the datapath
// strobes apply at a safe point.
module emu_osc_cfg_shadow
   import emu_osc_pkg::*;
#(
   parameter int DT_WIDTH = 27
) (
   input  logic                emu_clk,
   input  logic                emu_rst_n,
   emu_osc_timekeeper_if.slave cfg,
   input  logic                apply,
   output logic                full,
   output logic [DT_WIDTH-1:0] sh_lo,
   output logic [DT_WIDTH-1:0] sh_hi
);

   logic load;

   assign load          = cfg.cfg_valid & ~full;
   assign cfg.cfg_ready = ~full;

   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n) begin
         full  <= 1'b0;
         sh_lo <= '0;
         sh_hi <= '0;
      end else if (apply) begin
         full  <= 1'b0;
      end else if (load) begin
         full  <= 1'b1;
         sh_lo <= cfg.cfg_lo;
         sh_hi <= cfg.cfg_hi;
      end
   end

endmodule

// File: rtl/emu_osc_timekeeper.sv
// Emulated-time oscillator: counts down time to the next edge and
// requests that as the maximum timestep.
module emu_osc_timekeeper
   import emu_osc_pkg::*;
#(
   parameter int DT_WIDTH   = 27,
   parameter int CNT_WIDTH  = 32,
   parameter int LO_DEFAULT = 100,
   parameter int HI_DEFAULT = 100
) (
   input  logic                 emu_clk,
   input  logic                 emu_rst_n,
   input  logic                 enable,
   input  logic [DT_WIDTH-1:0]  emu_dt,
   output logic [DT_WIDTH-1:0]  dt_req,
   output logic                 clk_val,
   emu_osc_timekeeper_if.slave  cfg,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic                 overshoot_err
);

   localparam logic [DT_WIDTH-1:0] DT_ONES =
      DT_WIDTH'(dt_max(DT_WIDTH));
   localparam logic [DT_WIDTH-1:0] LO_RST =
      DT_WIDTH'(clamp1(64'(LO_DEFAULT)));
   localparam logic [DT_WIDTH-1:0] HI_RST =
      DT_WIDTH'(clamp1(64'(HI_DEFAULT)));

   osc_state_t          state_q, state_d;
   logic [DT_WIDTH-1:0] t_rem_q, t_rem_d;
   logic [DT_WIDTH-1:0] lo_q, hi_q, lo_d, hi_d;
   logic [DT_WIDTH-1:0] dt_d;
   logic [DT_WIDTH-1:0] sh_lo, sh_hi, sh_lo_c, sh_hi_c;
   logic [DT_WIDTH-1:0] next_lo;
   logic                clk_d, cnt_inc, ovs, apply, hit, sh_full;

   emu_osc_cfg_shadow #(
      .DT_WIDTH (DT_WIDTH)
   ) u_shadow (
      .emu_clk   (emu_clk),
      .emu_rst_n (emu_rst_n),
      .cfg       (cfg),
      .apply     (apply),
      .full      (sh_full),
      .sh_lo     (sh_lo),
      .sh_hi     (sh_hi)
   );

   assign sh_lo_c = DT_WIDTH'(clamp1(64'(sh_lo)));
   assign sh_hi_c = DT_WIDTH'(clamp1(64'(sh_hi)));
   assign next_lo = sh_full ? sh_lo_c : lo_q;
   assign hit     = (emu_dt != '0) && (emu_dt >= t_rem_q);

   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: state_d = enable ? LOW : IDLE;
         LOW: begin
            if (!enable)  state_d = IDLE;
            else if (hit) state_d = HIGH;
         end
         HIGH: begin
            if (!enable)  state_d = IDLE;
            else if (hit) state_d = LOW;
         end
         default: state_d = IDLE;
      endcase
   end

   // Enable drop beats a coincident edge and ignores emu_dt.
   always_comb begin
      t_rem_d = t_rem_q;
      clk_d   = clk_val;
      cnt_inc = 1'b0;
      ovs     = 1'b0;
      apply   = 1'b0;
      unique case (state_q)
         IDLE: begin
            apply   = sh_full;
            clk_d   = 1'b0;
            t_rem_d = enable ? next_lo : '0;
         end
         LOW: begin
            if (!enable) begin
               t_rem_d = '0;
               clk_d   = 1'b0;
            end else if (hit) begin
               clk_d   = 1'b1;
               t_rem_d = hi_q;
               cnt_inc = 1'b1;
               ovs     = emu_dt > t_rem_q;
            end else begin
               t_rem_d = t_rem_q - emu_dt;
            end
         end
         HIGH: begin
            if (!enable) begin
               t_rem_d = '0;
               clk_d   = 1'b0;
            end else if (hit) begin
               clk_d   = 1'b0;
               apply   = sh_full;
               t_rem_d = next_lo;
               ovs     = emu_dt > t_rem_q;
            end else begin
               t_rem_d = t_rem_q - emu_dt;
            end
         end
         default: begin
            t_rem_d = '0;
            clk_d   = 1'b0;
         end
      endcase
      lo_d = apply ? sh_lo_c : lo_q;
      hi_d = apply ? sh_hi_c : hi_q;
      dt_d = (state_d == IDLE) ? DT_ONES : t_rem_d;
   end

   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n) begin
         t_rem_q       <= '0;
         lo_q          <= LO_RST;
         hi_q          <= HI_RST;
         clk_val       <= 1'b0;
         dt_req        <= DT_ONES;
         cycle_count   <= '0;
         overshoot_err <= 1'b0;
      end else begin
         t_rem_q <= t_rem_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         clk_val <= clk_d;
         dt_req  <= dt_d;
         if (cnt_inc) cycle_count <= cycle_count + CNT_WIDTH'(1);
         if (ovs)     overshoot_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_emu_osc_timekeeper.sv
// Randomized bench for emu_osc_timekeeper against a phase-level
// reference model, plus directed literal checkpoints.
module tb_emu_osc_timekeeper;

   localparam int DW = 27;
   localparam int unsigned ONES = (1 << DW) - 1;

   logic          emu_clk = 1'b0;
   logic          emu_rst_n = 1'b0;
   logic          enable = 1'b0;
   logic [DW-1:0] emu_dt = '0;
   logic [DW-1:0] dt_req;
   logic          clk_val;
   logic [31:0]   cycle_count;
   logic          overshoot_err;

   int n_chk = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   emu_osc_timekeeper_if #(.DT_WIDTH(DW)) cfg_if ();

   emu_osc_timekeeper #(
      .DT_WIDTH(DW), .CNT_WIDTH(32),
      .LO_DEFAULT(100), .HI_DEFAULT(100)
   ) dut (
      .emu_clk       (emu_clk),
      .emu_rst_n     (emu_rst_n),
      .enable        (enable),
      .emu_dt        (emu_dt),
      .dt_req        (dt_req),
      .clk_val       (clk_val),
      .cfg           (cfg_if),
      .cycle_count   (cycle_count),
      .overshoot_err (overshoot_err)
   );

   always #5 emu_clk = ~emu_clk;

   // Model: running flag, current level, time left in this phase.
   bit          m_run, m_high, m_clk, m_err, m_full;
   int unsigned m_rem, m_lo, m_hi, m_slo, m_shi, m_count, m_dtreq;

   function automatic int unsigned cl1(input int unsigned v);
      return (v == 0) ? 1 : v;
   endfunction

   task automatic model_reset();
      m_run = 0; m_high = 0; m_clk = 0; m_err = 0; m_full = 0;
      m_rem = 0; m_lo = 100; m_hi = 100; m_slo = 0; m_shi = 0;
      m_count = 0; m_dtreq = ONES;
   endtask

   task automatic take_shadow();
      if (m_full) begin
         m_lo = cl1(m_slo); m_hi = cl1(m_shi); m_full = 0;
      end
   endtask

   task automatic model_step();
      bit fire;
      int unsigned d;
      fire = cfg_if.cfg_valid && !m_full;
      d = emu_dt;
      if (!m_run) begin
         take_shadow();
         m_clk = 0;
         if (enable) begin m_run = 1; m_high = 0; m_rem = m_lo; end
      end else if (!enable) begin
         m_run = 0; m_clk = 0;
      end else if (d != 0) begin
         if (d < m_rem) m_rem = m_rem - d;
         else begin
            if (d > m_rem) m_err = 1;
            m_high = !m_high;
            m_clk = m_high;
            if (m_high) begin m_rem = m_hi; m_count++; end
            else begin take_shadow(); m_rem = m_lo; end
         end
      end
      if (fire) begin
         m_full = 1; m_slo = cfg_if.cfg_lo; m_shi = cfg_if.cfg_hi;
      end
      m_dtreq = m_run ? m_rem : ONES;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge emu_clk) begin
      if (chk_on) begin
         chk("clk_val", 64'(clk_val), 64'(m_clk));
         chk("dt_req", 64'(dt_req), 64'(m_dtreq));
         chk("cfg_ready", 64'(cfg_if.cfg_ready), 64'(!m_full));
         chk("cycle_count", 64'(cycle_count), 64'(m_count));
         chk("overshoot", 64'(overshoot_err), 64'(m_err));
      end
   end

   task automatic step(input logic en, input int unsigned d);
      enable = en;
      emu_dt = DW'(d);
      @(posedge emu_clk);
      if (emu_rst_n) model_step();
      @(negedge emu_clk);
      #1;
   endtask

   task automatic offer(input bit v, input int unsigned lo,
                        input int unsigned hi);
      cfg_if.cfg_valid = v;
      cfg_if.cfg_lo = DW'(lo);
      cfg_if.cfg_hi = DW'(hi);
   endtask

   task automatic pin_reset(input string tag);
      chk({tag, "_clk"}, 64'(clk_val), 0);
      chk({tag, "_dt"}, 64'(dt_req), 64'(ONES));
      chk({tag, "_rdy"}, 64'(cfg_if.cfg_ready), 1);
      chk({tag, "_cnt"}, 64'(cycle_count), 0);
      chk({tag, "_err"}, 64'(overshoot_err), 0);
   endtask

   initial begin
      int unsigned d, r;
      bit en;
      offer(0, 0, 0);
      model_reset();
      chk_on = 1'b1;
      repeat (3) @(posedge emu_clk);
      @(negedge emu_clk);
      #1;
      pin_reset("rst");
      emu_rst_n = 1'b1;

      step(1, 0);
      chk("first_dt", 64'(dt_req), 100);
      for (int i = 0; i < 6; i++) step(1, m_dtreq);
      chk("track_cnt", 64'(cycle_count), 3);
      chk("track_clk", 64'(clk_val), 0);

      repeat (3) step(1, 30);
      chk("dt_after_90", 64'(dt_req), 10);
      step(1, 10);
      chk("rise_dt", 64'(dt_req), 100);
      chk("rise_cnt", 64'(cycle_count), 4);
      repeat (3) step(1, 30);
      step(1, 30);
      chk("ovs_set", 64'(overshoot_err), 1);
      step(1, 5);
      chk("ovs_sticky", 64'(overshoot_err), 1);

      step(1, 95);
      step(1, 40);
      offer(1, 50, 20);
      step(1, 10);
      offer(0, 0, 0);
      chk("cfg_busy", 64'(cfg_if.cfg_ready), 0);
      step(1, 20);
      chk("cfg_busy2", 64'(cfg_if.cfg_ready), 0);
      step(1, 30);
      chk("new_lo", 64'(dt_req), 50);
      chk("cfg_free", 64'(cfg_if.cfg_ready), 1);
      step(1, 50);
      chk("new_hi", 64'(dt_req), 20);
      step(1, 20);
      repeat (10) step(1, 0);
      chk("frozen_dt", 64'(dt_req), 50);

      offer(1, 0, 20);
      step(1, 10);
      offer(0, 0, 0);
      step(1, 40);
      step(1, 20);
      chk("clamp_lo", 64'(dt_req), 1);
      step(0, 1);
      chk("drop_clk", 64'(clk_val), 0);
      chk("drop_dt", 64'(dt_req), 64'(ONES));
      chk("drop_cnt", 64'(cycle_count), 7);

      step(0, 0);
      offer(1, 100, 100);
      step(0, 0);
      offer(0, 0, 0);
      step(0, 0);
      chk("idle_apply_rdy", 64'(cfg_if.cfg_ready), 1);
      step(1, 0);
      chk("idle_apply_lo", 64'(dt_req), 100);
      step(1, 100);
      step(1, 30);

      #2;
      emu_rst_n = 1'b0;
      model_reset();
      #1;
      pin_reset("arst");
      repeat (2) @(posedge emu_clk);
      @(negedge emu_clk);
      emu_rst_n = 1'b1;
      #1;
      step(1, 0);
      chk("post_rst_dt", 64'(dt_req), 100);
      step(1, 100);
      chk("post_rst_cnt", 64'(cycle_count), 1);

      for (int i = 0; i < 800; i++) begin
         en = ($urandom_range(0, 19) != 0);
         r = $urandom_range(0, 9);
         if (!m_run)     d = $urandom_range(0, 5);
         else if (r < 5) d = m_dtreq;
         else if (r < 7) d = $urandom_range(0, m_dtreq - 1);
         else if (r < 9) d = 0;
         else            d = m_dtreq + $urandom_range(1, 3);
         offer($urandom_range(0, 3) == 0,
               $urandom_range(0, 6), $urandom_range(0, 6));
         step(en, d);
      end

      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/emu_osc_timekeeper.md
Name: emu_osc_timekeeper

Overview:
- Emulated-time oscillator that produces the clock-value request (`clk_val_*`) and timestep request (`dt_req`) consumed by the emulator clock generator and time manager.
- Tracks remaining emulated time to the next oscillator edge, advances it by the global timestep `emu_dt` each `emu_clk` cycle, and toggles `clk_val` exactly when an edge is reached.
- Sits on the producer side of `gen_emu_clks`: its `clk_val` output drives `clk_val_<osc>` there.

Parameters:
- DT_WIDTH, 27, width of `emu_dt`, `dt_req` and half-period values (emulated-time LSB units).
- CNT_WIDTH, 32, width of rising-edge counter.
- LO_DEFAULT, 100, low half-period loaded at reset.
- HI_DEFAULT, 100, high half-period loaded at reset.

Ports:
- emu_clk  input  1  emulator clock; all state updates on posedge.
- emu_rst_n  input  1  asynchronous active-low reset.
- enable  input  1  oscillator run enable.
- emu_dt  input  DT_WIDTH  timestep taken this cycle (global min of all requests).
- dt_req  output  DT_WIDTH  requested max timestep (time to next edge).
- clk_val  output  1  oscillator value to clock generator.
- cfg_valid  input  1  new half-periods offered.
- cfg_ready  output  1  shadow register free.
- cfg_lo  input  DT_WIDTH  new low half-period.
- cfg_hi  input  DT_WIDTH  new high half-period.
- cycle_count  output  CNT_WIDTH  rising edges since reset (wraps).
- overshoot_err  output  1  sticky: `emu_dt` exceeded `dt_req`.

Behaviour:
- Interface: one clock `emu_clk`; reset `emu_rst_n` is asynchronous and active-low. Every register clears on assertion regardless of clock; release is synchronous to `emu_clk`.
- Reset values:
  - `clk_val`=0, `dt_req`=all ones, `cfg_ready`=1, `cycle_count`=0, `overshoot_err`=0.
  - Internal: `t_rem`=0, active `lo`/`hi` = `LO_DEFAULT`/`HI_DEFAULT`, shadow empty.
- States: IDLE, LOW, HIGH.
- IDLE (`enable`=0):
  - `clk_val`=0, `dt_req`=all ones (no constraint).
  - A pending shadow config is copied to active immediately.
  - On `enable`=1: `t_rem` <= `lo`, go to LOW. The first rising edge occurs after `lo` units.
- LOW/HIGH, per cycle, with `d` = `emu_dt`:
  - `d`==0: no change.
  - `d` < `t_rem`: `t_rem` <= `t_rem` − `d`.
  - `d` == `t_rem`: edge.
    - LOW->HIGH: `clk_val` <= 1, `t_rem` <= `hi`, `cycle_count`++.
    - HIGH->LOW: `clk_val` <= 0; if shadow full, copy shadow to active first; then `t_rem` <= new `lo`.
  - `d` > `t_rem`: same as `d`==`t_rem` (edge taken, no carry of excess), and `overshoot_err` <= 1 (sticky until reset).
- `dt_req` is registered and equals `t_rem` after the update, i.e. valid one cycle after `emu_dt` is sampled. Combinational path `emu_dt`->`dt_req` is forbidden.
- Zero half-period in `cfg` or defaults is clamped to 1 on load.
- Config handshake:
  - Transfer when `cfg_valid` && `cfg_ready`; the shadow is captured and `cfg_ready` <= 0.
  - `cfg_ready` returns to 1 the cycle after shadow is applied (at HIGH->LOW edge or in IDLE).
  - New periods never take effect mid-phase; duty changes are glitch-free.
- `enable` deassert in LOW/HIGH: next cycle go to IDLE, `clk_val` <= 0, `t_rem` discarded. If in HIGH, the truncated pulse is accepted; `cycle_count` is unaffected.
- Simultaneous edge and `enable` drop: `enable` wins (IDLE, `clk_val`=0).
- `cycle_count` wraps modulo 2^CNT_WIDTH with no flag.
- Arithmetic: unsigned DT_WIDTH; subtraction only when `d` < `t_rem`, so no underflow.

Decomposition:
- Package `emu_osc_pkg`:
  - `osc_state_t` enum (IDLE, LOW, HIGH).
  - `DT_MAX` constant function of DT_WIDTH.
  - Clamp-to-1 helper function.
- One sub-module is natural: `emu_osc_cfg_shadow`, holding the valid/ready shadow register pair with load/apply strobes.
- Time/state datapath stays in the top.

Test Plan:
- Reset, `enable`=1, `emu_dt` tracks `dt_req` each cycle (100, 100, ...) -> `clk_val` toggles every cycle, `dt_req`=100, `cycle_count` increments every 2 cycles, `overshoot_err`=0.
- `enable`=1, `emu_dt`=30 fixed -> `t_rem` 100, 70, 40, 10; next `emu_dt`=10 -> rising edge, `dt_req`=100. With `emu_dt`=30 instead of 10 -> `overshoot_err`=1 and stays 1.
- Mid-HIGH `cfg_lo`=50 / `cfg_hi`=20 accepted -> `cfg_ready`=0 until the falling edge. Next LOW lasts 50 and next HIGH lasts 20; `cfg_ready`=1 the cycle after the falling edge.
- `emu_dt`=0 for 10 cycles -> outputs frozen. `cfg_lo`=0 -> LOW half-period is 1.
- `enable` dropped on the same cycle `t_rem` hits 0 in LOW -> IDLE, `clk_val`=0, `cycle_count` unchanged, `dt_req`=all ones.
- Assert `emu_rst_n`=0 asynchronously mid-HIGH -> all outputs at reset values immediately. After release, first rising edge after `LO_DEFAULT`.
